// File: rtl/apb_master_bridge.sv
// Valid/ready command to APB3 master bridge with registered APB outputs and a
// watchdog that aborts ACCESS phases whose slave never raises PREADY.
module apb_master_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  localparam int unsigned      CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  always_ff @(posedge pclk_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          pwrite_d = cmd_write_i;
          paddr_d  = cmd_addr_i;
          pwdata_d = cmd_wdata_i;
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready_i) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
          rsp_err_d     = pslverr_i;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = S_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = S_RESP;
        end else if (cnt_q != '1) begin
          // Saturate so a disabled watchdog never wraps back to zero.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d   = 1'b0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed and random transfers against a
// transaction-level model of the expected APB phase counts and responses.
module tb_apb_master_bridge;

  localparam int unsigned TMO = 4;

  logic        pclk_i = 1'b0;
  logic        rst_n_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_timeout_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o, prdata_i;
  logic        pready_i, pslverr_i;

  int unsigned checks = 0;
  int unsigned failures = 0;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .pclk_i(pclk_i), .rst_n_i(rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk_i);
    @(negedge pclk_i);
  endtask

  // One complete transfer; the slave inserts `waits` wait states before PREADY.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int unsigned waits, input logic slverr,
                         input logic [31:0] rdata, input int unsigned hold);
    bit          timed_out, stable_ok, hold_ok;
    int unsigned acc_exp, nsetup, nacc, cyc;
    logic [31:0] rd_exp;
    logic        err_exp;
    timed_out = (TMO > 0) && (waits >= TMO);
    acc_exp   = timed_out ? TMO : waits + 1;
    rd_exp    = (wr || timed_out) ? 32'd0 : rdata;
    err_exp   = timed_out || slverr;
    chk("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wdata;
    step();
    cmd_valid_i = 1'b0; cmd_write_i = 1'($urandom); cmd_addr_i = $urandom; cmd_wdata_i = $urandom;
    nsetup = 0; nacc = 0; cyc = 0; stable_ok = 1'b1;
    while (!rsp_valid_o && cyc < 64) begin
      if (psel_o && !penable_o) nsetup++;
      if (psel_o && penable_o) begin
        nacc++;
        pready_i  = (nacc == waits + 1);
        pslverr_i = pready_i ? slverr : 1'($urandom);
        prdata_i  = pready_i ? rdata : $urandom;
      end
      if (paddr_o !== addr || pwrite_o !== wr || pwdata_o !== wdata) stable_ok = 1'b0;
      step();
      cyc++;
    end
    pready_i = 1'b0; pslverr_i = 1'($urandom); prdata_i = $urandom;
    chk("rsp_valid_rise", 64'(rsp_valid_o), 64'd1);
    chk("setup_cycles", 64'(nsetup), 64'd1);
    chk("access_cycles", 64'(nacc), 64'(acc_exp));
    chk("rsp_rdata", 64'(rsp_rdata_o), 64'(rd_exp));
    chk("rsp_err", 64'(rsp_err_o), 64'(err_exp));
    chk("rsp_timeout", 64'(rsp_timeout_o), 64'(timed_out));
    chk("psel_after", 64'({psel_o, penable_o}), 64'd0);
    chk("cmd_ready_resp", 64'(cmd_ready_o), 64'd0);
    chk("ctrl_stable", 64'(stable_ok), 64'd1);
    hold_ok = 1'b1;
    for (int unsigned h = 0; h < hold; h++) begin
      step();
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== rd_exp || rsp_err_o !== err_exp ||
          rsp_timeout_o !== timed_out || psel_o !== 1'b0 || cmd_ready_o !== 1'b0) hold_ok = 1'b0;
    end
    chk("rsp_hold", 64'(hold_ok), 64'd1);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk("rsp_cleared", 64'({rsp_valid_o, rsp_err_o, rsp_timeout_o}), 64'd0);
    chk("rdata_kept", 64'(rsp_rdata_o), 64'(rd_exp));
    chk("ready_again", 64'(cmd_ready_o), 64'd1);
    chk("addr_kept", 64'(paddr_o), 64'(addr));
  endtask

  initial begin
    int unsigned nsetup, nrsp, issued, last_setup;
    bit          overlap;
    rst_n_i = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    rsp_ready_i = 1'b0; prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    repeat (3) step();
    chk("reset_outputs", 64'({cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o,
                              psel_o, penable_o, pwrite_o}), 64'b1000000);
    chk("reset_data", 64'(paddr_o | pwdata_o | rsp_rdata_o), 64'd0);
    rst_n_i = 1'b1;
    step();

    // Directed scenarios from the test plan
    do_xfer(1'b1, 32'd2, 32'hF, 0, 1'b0, 32'hDEAD, 0);
    do_xfer(1'b0, 32'd5, 32'h0, 3, 1'b0, 32'h3, 1);
    do_xfer(1'b0, 32'd7, 32'h0, 50, 1'b0, 32'h55, 0);
    do_xfer(1'b1, 32'd9, 32'h1234, 0, 1'b1, 32'h0, 5);

    // Back-to-back reads of addr 2..8 with command valid held high
    nsetup = 0; nrsp = 0; issued = 0; last_setup = 0; overlap = 1'b0;
    pready_i = 1'b1; rsp_ready_i = 1'b1; cmd_write_i = 1'b0; cmd_valid_i = 1'b1;
    for (int unsigned cyc = 0; cyc < 80 && nrsp < 7; cyc++) begin
      if (psel_o && !penable_o) begin
        chk("b2b_order", 64'(paddr_o), 64'(2 + nsetup));
        if (nsetup > 0) chk("b2b_spacing", 64'(cyc - last_setup), 64'd4);
        last_setup = cyc;
        nsetup++;
      end
      prdata_i = paddr_o * 3 + 1;
      if (rsp_valid_o) begin
        chk("b2b_rdata", 64'(rsp_rdata_o), 64'((2 + nrsp) * 3 + 1));
        nrsp++;
      end
      if (rsp_valid_o && psel_o) overlap = 1'b1;
      if (cmd_ready_o) begin
        if (issued < 7) begin
          cmd_addr_i = 2 + issued;
          issued++;
        end else cmd_valid_i = 1'b0;
      end
      step();
    end
    cmd_valid_i = 1'b0; pready_i = 1'b0; rsp_ready_i = 1'b0;
    chk("b2b_rsp_count", 64'(nrsp), 64'd7);
    chk("b2b_setup_count", 64'(nsetup), 64'd7);
    chk("b2b_no_overlap", 64'(overlap), 64'd0);
    step();

    // Reset during ACCESS of a read
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'd6;
    step();
    cmd_valid_i = 1'b0;
    step();
    step();
    chk("pre_reset_access", 64'({psel_o, penable_o}), 64'b11);
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    chk("reset_mid_apb", 64'({psel_o, penable_o}), 64'd0);
    chk("reset_mid_ready", 64'(cmd_ready_o), 64'd1);
    chk("reset_mid_rsp", 64'(rsp_valid_o), 64'd0);
    step();
    do_xfer(1'b0, 32'd3, 32'h0, 1, 1'b0, 32'hA5A5, 0);

    // Random transfers, including some past the watchdog limit
    for (int i = 0; i < 16; i++) begin
      do_xfer(1'($urandom), $urandom, $urandom, $urandom_range(0, 6), 1'($urandom),
              $urandom, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
